// File: rtl/mem_bus_pkg.sv
// Shared encodings for the on-chip memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_IF = 2'd1,
    ST_GNT_DM = 2'd2
  } arb_state_e;

  // Access size/sign codes (funct3 encoding)
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_D  = 3'b011;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam logic [2:0] SZ_WU = 3'b110;

  // Instruction fetch always moves a full doubleword
  localparam logic [2:0] IF_FETCH_SIZE = SZ_D;

endpackage

// File: rtl/mem_bus_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module arb_sat_counter
  import mem_bus_pkg::*;
#(
  parameter int unsigned CNT_W = 5,
  parameter int unsigned LIMIT = 31
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, else step until the limit is reached
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < LIMIT_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch, data) arbiter and sequencer for the shared ROM/RAM bus.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_write,
  input  logic [2:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_write,
  output logic [2:0]        bus_size,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic              bus_err,
  output logic              stall
);

  localparam bit               TO_EN       = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STARVE_MAX  = CNT_W'(STARVE_LIMIT);
  localparam int unsigned      WAIT_LIMIT  = (2 ** CNT_W) - 1;

  arb_state_e        state_q,     state_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_write_q, bus_write_d;
  logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
  logic [2:0]        bus_size_q,  bus_size_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              granted;
  logic              timeout_hit;
  logic              xfer_done;
  logic              starve_clr;
  logic              starve_inc;
  logic              wait_clr;
  logic              wait_inc;

  // Transfer completion: slave ready, or the wait budget is exhausted
  always_comb begin
    granted     = (state_q != ST_IDLE);
    timeout_hit = TO_EN && granted && !bus_ready && (wait_cnt == TO_LAST);
    xfer_done   = granted && (bus_ready || timeout_hit);
  end

  // Grant decision and address/data latching
  always_comb begin
    state_d     = state_q;
    bus_valid_d = bus_valid_q;
    bus_write_d = bus_write_q;
    bus_addr_d  = bus_addr_q;
    bus_size_d  = bus_size_q;
    bus_wdata_d = bus_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (dm_req && !(if_req && (starve_cnt >= STARVE_MAX))) begin
          state_d     = ST_GNT_DM;
          bus_valid_d = 1'b1;
          bus_write_d = dm_write;
          bus_addr_d  = dm_addr;
          bus_size_d  = dm_size;
          bus_wdata_d = dm_wdata;
        end else if (if_req) begin
          state_d     = ST_GNT_IF;
          bus_valid_d = 1'b1;
          bus_write_d = 1'b0;
          bus_addr_d  = if_addr;
          bus_size_d  = IF_FETCH_SIZE;
          bus_wdata_d = '0;
        end
      end
      ST_GNT_IF, ST_GNT_DM: begin
        if (xfer_done) begin
          state_d     = ST_IDLE;
          bus_valid_d = 1'b0;
          bus_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        bus_valid_d = 1'b0;
        bus_write_d = 1'b0;
      end
    endcase
  end

  // State and latched bus copies
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      bus_valid_q <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_size_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_write_q <= bus_write_d;
      bus_addr_q  <= bus_addr_d;
      bus_size_q  <= bus_size_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Counter controls: fetch starvation and granted wait cycles
  always_comb begin
    starve_clr = !if_req || ((state_q == ST_IDLE) && (state_d == ST_GNT_IF));
    starve_inc = if_req && (state_q != ST_GNT_IF);
    wait_clr   = (state_q == ST_IDLE);
    wait_inc   = granted && !bus_ready;
  end

  arb_sat_counter #(
    .CNT_W (CNT_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (starve_clr),
    .inc   (starve_inc),
    .cnt   (starve_cnt)
  );

  arb_sat_counter #(
    .CNT_W (CNT_W),
    .LIMIT (WAIT_LIMIT)
  ) u_wait_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .cnt   (wait_cnt)
  );

  // Same-cycle acknowledge and read-data return; aborted transfers return zero
  always_comb begin
    if_ack   = (state_q == ST_GNT_IF) && xfer_done;
    dm_ack   = (state_q == ST_GNT_DM) && xfer_done;
    bus_err  = timeout_hit;
    if_rdata = (if_ack && bus_ready) ? bus_rdata : '0;
    dm_rdata = (dm_ack && bus_ready) ? bus_rdata : '0;
    stall    = (if_req && !if_ack) || (dm_req && !dm_ack);
  end

  assign bus_valid = bus_valid_q;
  assign bus_write = bus_write_q;
  assign bus_addr  = bus_addr_q;
  assign bus_size  = bus_size_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transfers, arbitration, waits, timeout, reset abort.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic          CLK;
  logic          RESET;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          dm_req;
  logic          dm_write;
  logic [2:0]    dm_size;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ready;

  logic          if_ack, dm_ack, bus_valid, bus_write, bus_err, stall;
  logic [DW-1:0] if_rdata, dm_rdata, bus_wdata;
  logic [AW-1:0] bus_addr;
  logic [2:0]    bus_size;

  logic          nt_if_ack, nt_dm_ack, nt_bus_valid, nt_bus_write, nt_bus_err, nt_stall;
  logic [DW-1:0] nt_if_rdata, nt_dm_rdata, nt_bus_wdata;
  logic [AW-1:0] nt_bus_addr;
  logic [2:0]    nt_bus_size;

  typedef struct {
    bit            master;   // 0 = fetch, 1 = data
    logic [DW-1:0] rdata;
    bit            err;
    logic [AW-1:0] addr;
    bit            write;
    logic [DW-1:0] wdata;
    logic [2:0]    size;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_bus_arbiter #(.TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_write(dm_write), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_size(bus_size), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .bus_err(bus_err), .stall(stall)
  );

  mem_bus_arbiter #(.TIMEOUT(0)) dut_nt (
    .CLK(CLK), .RESET(RESET),
    .if_req(if_req), .if_addr(if_addr), .if_ack(nt_if_ack), .if_rdata(nt_if_rdata),
    .dm_req(dm_req), .dm_write(dm_write), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(nt_dm_ack), .dm_rdata(nt_dm_rdata),
    .bus_valid(nt_bus_valid), .bus_addr(nt_bus_addr), .bus_write(nt_bus_write),
    .bus_size(nt_bus_size), .bus_wdata(nt_bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .bus_err(nt_bus_err), .stall(nt_stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input bit m, input logic [DW-1:0] rd, input bit er, input logic [AW-1:0] a,
                      input bit w, input logic [DW-1:0] wd, input logic [2:0] sz);
    exp_t e;
    e.master = m; e.rdata = rd; e.err = er; e.addr = a; e.write = w; e.wdata = wd; e.size = sz;
    exp_q.push_back(e);
  endtask

  // Drive point: just after the active edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Check point: opposite edge
  task automatic sample();
    @(negedge CLK);
  endtask

  // Monitor: every acknowledge pops one expected transfer and is compared against it
  always @(negedge CLK) begin
    if (RESET) begin
      if (if_ack && dm_ack) chk("both_acks", 64'(1), 64'(0));
      if (if_ack || dm_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_master", 64'(dm_ack), 64'(e.master));
          chk("ack_rdata", dm_ack ? dm_rdata : if_rdata, e.rdata);
          chk("ack_err", 64'(bus_err), 64'(e.err));
          chk("ack_valid", 64'(bus_valid), 64'(1));
          chk("ack_addr", bus_addr, e.addr);
          chk("ack_write", 64'(bus_write), 64'(e.write));
          chk("ack_wdata", bus_wdata, e.wdata);
          chk("ack_size", 64'(bus_size), 64'(e.size));
        end
      end else if (bus_err) begin
        chk("err_without_ack", 64'(1), 64'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_cyc;
    int nt_bad;
    RESET = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_write = 1'b0;
    dm_size = '0; dm_addr = '0; dm_wdata = '0; bus_rdata = '0; bus_ready = 1'b0;

    // Reset state
    sample();
    chk("rst_valid", 64'(bus_valid), 64'(0));
    chk("rst_acks", 64'({if_ack, dm_ack, bus_err}), 64'(0));
    chk("rst_addr", bus_addr, 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    tick(); RESET = 1'b1;

    // 1: single fetch, ready on first granted cycle
    tick(); if_req = 1'b1; if_addr = 64'h1000; bus_ready = 1'b1; bus_rdata = 64'h13;
    push(0, 64'h13, 0, 64'h1000, 0, 64'h0, 3'b011);
    sample(); chk("t1_stall_c0", 64'(stall), 64'(1)); chk("t1_valid_c0", 64'(bus_valid), 64'(0));
    tick();
    sample(); chk("t1_valid_c1", 64'(bus_valid), 64'(1)); chk("t1_ack_c1", 64'(if_ack), 64'(1));
    chk("t1_stall_c1", 64'(stall), 64'(0));
    tick(); if_req = 1'b0;
    sample(); chk("t1_valid_c2", 64'(bus_valid), 64'(0));

    // 2: simultaneous requests, data wins, then fetch after an idle cycle
    tick(); if_req = 1'b1; if_addr = 64'h2000; dm_req = 1'b1; dm_write = 1'b1;
    dm_addr = 64'h8000_0010; dm_wdata = 64'hCAFE; dm_size = 3'b011; bus_rdata = 64'h0;
    push(1, 64'h0, 0, 64'h8000_0010, 1, 64'hCAFE, 3'b011);
    push(0, 64'h77, 0, 64'h2000, 0, 64'h0, 3'b011);
    sample(); chk("t2_valid_c0", 64'(bus_valid), 64'(0));
    tick();
    sample(); chk("t2_dmack_c1", 64'(dm_ack), 64'(1)); chk("t2_ifack_c1", 64'(if_ack), 64'(0));
    tick(); dm_req = 1'b0; dm_write = 1'b0; bus_rdata = 64'h77;
    sample(); chk("t2_valid_c2", 64'(bus_valid), 64'(0)); chk("t2_write_c2", 64'(bus_write), 64'(0));
    chk("t2_stall_c2", 64'(stall), 64'(1));
    tick();
    sample(); chk("t2_ifack_c3", 64'(if_ack), 64'(1));
    tick(); if_req = 1'b0;
    sample(); chk("t2_valid_c4", 64'(bus_valid), 64'(0));

    // 3: starvation forces fetch ahead of a held data request
    tick(); if_req = 1'b1; if_addr = 64'h3000; dm_req = 1'b1; dm_addr = 64'h4000;
    dm_size = 3'b010; dm_wdata = 64'h0; bus_rdata = 64'h99;
    push(1, 64'h99, 0, 64'h4000, 0, 64'h0, 3'b010);
    push(1, 64'h99, 0, 64'h4000, 0, 64'h0, 3'b010);
    push(0, 64'h99, 0, 64'h3000, 0, 64'h0, 3'b011);
    sample(); chk("t3_starve_c0", 64'(dut.starve_cnt), 64'(0));
    tick(); sample(); chk("t3_dmack_c1", 64'(dm_ack), 64'(1));
    tick(); sample(); chk("t3_starve_c2", 64'(dut.starve_cnt), 64'(2));
    tick(); sample(); chk("t3_dmack_c3", 64'(dm_ack), 64'(1));
    tick(); sample(); chk("t3_starve_c4", 64'(dut.starve_cnt), 64'(4));
    chk("t3_valid_c4", 64'(bus_valid), 64'(0));
    tick(); sample(); chk("t3_ifack_c5", 64'(if_ack), 64'(1));
    chk("t3_starve_c5", 64'(dut.starve_cnt), 64'(0));
    tick(); if_req = 1'b0; dm_req = 1'b0;
    sample(); chk("t3_valid_c6", 64'(bus_valid), 64'(0));

    // 4: fetch with three wait states; address held despite input change
    tick(); if_req = 1'b1; if_addr = 64'h5000; bus_ready = 1'b0; bus_rdata = 64'hBAD;
    push(0, 64'h1234, 0, 64'h5000, 0, 64'h0, 3'b011);
    sample();
    for (int g = 1; g <= 3; g++) begin
      tick(); if (g == 2) if_addr = 64'h6000;
      sample(); chk("t4_wait_valid", 64'(bus_valid), 64'(1));
      chk("t4_wait_addr", bus_addr, 64'h5000);
      chk("t4_wait_noack", 64'(if_ack), 64'(0));
      chk("t4_wait_stall", 64'(stall), 64'(1));
    end
    tick(); bus_ready = 1'b1; bus_rdata = 64'h1234;
    sample(); chk("t4_ack", 64'(if_ack), 64'(1));
    tick(); if_req = 1'b0; bus_ready = 1'b0;
    sample(); chk("t4_valid_after", 64'(bus_valid), 64'(0));

    // 5: data load with slave stuck; timeout on the 16th granted cycle
    tick(); dm_req = 1'b1; dm_write = 1'b0; dm_addr = 64'h7000; dm_size = 3'b000;
    dm_wdata = 64'h0; bus_rdata = 64'hDEAD;
    push(1, 64'h0, 1, 64'h7000, 0, 64'h0, 3'b000);
    sample();
    ack_cyc = 0; nt_bad = 0;
    for (int g = 1; g <= 20; g++) begin
      tick(); sample();
      if (nt_if_ack || nt_dm_ack || nt_bus_err) nt_bad++;
      if (dm_ack) begin ack_cyc = g; break; end
    end
    chk("t5_timeout_cycle", 64'(ack_cyc), 64'(16));
    tick(); dm_req = 1'b0;
    sample(); chk("t5_valid_after", 64'(bus_valid), 64'(0)); chk("t5_err_after", 64'(bus_err), 64'(0));
    for (int g = 0; g < 12; g++) begin
      tick(); sample();
      if (nt_if_ack || nt_dm_ack || nt_bus_err) nt_bad++;
    end
    chk("t5_nt_never_acks", 64'(nt_bad), 64'(0));
    chk("t5_nt_still_valid", 64'(nt_bus_valid), 64'(1));

    // 6: reset mid-wait aborts with no ack; held request re-granted afterwards
    tick(); dm_req = 1'b1; dm_addr = 64'h9000; dm_size = 3'b011; bus_ready = 1'b0;
    sample();
    tick(); sample(); chk("t6_valid_c1", 64'(bus_valid), 64'(1));
    tick(); sample(); chk("t6_valid_c2", 64'(bus_valid), 64'(1));
    #2; RESET = 1'b0; #1;
    chk("t6_rst_valid", 64'(bus_valid), 64'(0));
    chk("t6_rst_ack_err", 64'({dm_ack, bus_err}), 64'(0));
    chk("t6_rst_nt_valid", 64'(nt_bus_valid), 64'(0));
    chk("t6_rst_stall", 64'(stall), 64'(1));
    tick(); tick(); RESET = 1'b1; bus_ready = 1'b1; bus_rdata = 64'h4242;
    push(1, 64'h4242, 0, 64'h9000, 0, 64'h0, 3'b011);
    sample();
    chk("t6_idle_valid", 64'(bus_valid), 64'(0));
    chk("t6_idle_wait", 64'(dut.wait_cnt), 64'(0));
    chk("t6_idle_starve", 64'(dut.starve_cnt), 64'(0));
    tick(); sample();
    chk("t6_regrant_ack", 64'(dm_ack), 64'(1));
    chk("t6_nt_ack", 64'(nt_dm_ack), 64'(1));
    chk("t6_nt_rdata", nt_dm_rdata, 64'h4242);
    chk("t6_nt_addr", nt_bus_addr, 64'h9000);
    chk("t6_nt_misc", 64'({nt_if_ack, nt_bus_write, nt_bus_err, nt_stall, nt_bus_size}), 64'(3));
    chk("t6_nt_data", nt_if_rdata | nt_bus_wdata, 64'h0);
    tick(); dm_req = 1'b0; bus_ready = 1'b0;
    sample(); chk("t6_valid_after", 64'(bus_valid), 64'(0));

    tick(); tick();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
